// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient table and FSM encoding for the CIC
// compensation FIR (11-tap symmetric, Q1.15 coefficients).
package cic_comp_pkg;

  localparam int NTAP  = 11;
  localparam int NHALF = 6;
  localparam int NCOEF = 16;
  localparam int ACCW  = 41;

  // Unique half of the symmetric impulse response, h[0] at index 0.
  // Values: -64, 256, -768, 2048, 6912, 16000 (sum of full response = 32768).
  localparam logic [NHALF-1:0][NCOEF-1:0] COEF = {
    16'h3E80,   // h[5] =  16000 (centre tap)
    16'h1B00,   // h[4] =   6912
    16'h0800,   // h[3] =   2048
    16'hFD00,   // h[2] =   -768
    16'h0100,   // h[1] =    256
    16'hFFC0    // h[0] =    -64
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/cic_comp_mac.sv
// Pre-add / multiply / accumulate datapath: acc += coef * (xa + xb), or
// coef * xa alone on the centre tap.
module cic_comp_mac
  import cic_comp_pkg::*;
#(
  parameter int NIN = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   step,
  input  logic                   mid,
  input  logic [NIN-1:0]         xa,
  input  logic [NIN-1:0]         xb,
  input  logic [NCOEF-1:0]       coef,
  output logic signed [ACCW-1:0] acc
);

  localparam int PW = NIN + 1 + NCOEF;

  logic signed [NIN:0]      pre;
  logic signed [NCOEF-1:0]  coef_s;
  logic signed [PW-1:0]     prod;
  logic signed [ACCW-1:0]   acc_d, acc_q;

  always_comb begin
    coef_s = coef;
    // Centre tap has no mirror partner, so it is not doubled.
    if (mid) pre = {xa[NIN-1], xa};
    else     pre = {xa[NIN-1], xa} + {xb[NIN-1], xb};
    prod  = pre * coef_s;
    acc_d = acc_q;
    if (clr)       acc_d = '0;
    else if (step) acc_d = acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop compensation FIR: delay line, IDLE/MAC/OUT sequencer and output
// rounding stage. Define CIC_COMP_SAT_EN to saturate instead of wrap.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int NIN   = 21,
  parameter int NOUT  = 16,
  parameter int SHIFT = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NIN-1:0]  din,
  output logic            valid,
  output logic [NOUT-1:0] dout,
  output logic            overrun
);

  state_e state_q, state_d;
  logic [2:0]                 k_q, k_d;
  logic [NTAP-1:0][NIN-1:0]   x_q, x_d;
  logic [NOUT-1:0]            dout_q, dout_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic                       accept;
  logic                       mac_clr, mac_step, mac_mid;
  logic [3:0]                 kb;
  logic [NIN-1:0]             xa, xb;
  logic signed [ACCW-1:0]     acc;
  logic signed [ACCW-1:0]     rnd, shr;
  logic [NOUT-1:0]            res;

  assign accept = en && (state_q == ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_MAC;
      ST_MAC:  if (k_q == 3'(NHALF-1)) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    x_d       = x_q;
    k_d       = k_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    overrun_d = en && (state_q != ST_IDLE);
    mac_clr   = accept;
    mac_step  = (state_q == ST_MAC);
    mac_mid   = (k_q == 3'(NHALF-1));
    if (accept) begin
      x_d = {x_q[NTAP-2:0], din};
      k_d = '0;
    end
    if (state_q == ST_MAC) k_d = k_q + 3'd1;
    if (state_q == ST_OUT) begin
      dout_d  = res;
      valid_d = 1'b1;
    end
  end

  // Tap pair selection: x[k] and its mirror x[NTAP-1-k].
  always_comb begin
    kb = 4'(NTAP-1) - {1'b0, k_q};
    xa = x_q[k_q];
    xb = x_q[kb];
  end

  cic_comp_mac #(.NIN(NIN)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .step (mac_step),
    .mid  (mac_mid),
    .xa   (xa),
    .xb   (xb),
    .coef (COEF[k_q]),
    .acc  (acc)
  );

  // Round half up, then reduce to the output width.
  always_comb begin
    rnd = acc + (ACCW'(1) << (SHIFT-1));
    shr = rnd >>> SHIFT;
`ifdef CIC_COMP_SAT_EN
    if ((&shr[ACCW-1:NOUT-1]) || ~(|shr[ACCW-1:NOUT-1]))
      res = NOUT'(shr);
    else if (shr[ACCW-1])
      res = {1'b1, {(NOUT-1){1'b0}}};
    else
      res = {1'b0, {(NOUT-1){1'b1}}};
`else
    res = NOUT'(shr);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      x_q       <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      k_q       <= k_d;
      x_q       <= x_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign dout    = dout_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomized self-checking bench for cic_comp_fir against a direct 11-tap
// convolution model. Honours CIC_COMP_SAT_EN the same way as the design.
module tb_cic_comp_fir;

  localparam int NIN   = 21;
  localparam int NOUT  = 16;
  localparam int SHIFT = 20;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [NIN-1:0]  din;
  logic            valid;
  logic [NOUT-1:0] dout;
  logic            overrun;

  int total = 0;
  int bad   = 0;
  longint hist[$];
  longint last_exp;

  always #5 clk = ~clk;

  cic_comp_fir #(.NIN(NIN), .NOUT(NOUT), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .valid(valid), .dout(dout), .overrun(overrun)
  );

  function automatic longint hfull(input int i);
    int j;
    j = (i <= 5) ? i : 10 - i;
    case (j)
      0: return -64;
      1: return 256;
      2: return -768;
      3: return 2048;
      4: return 6912;
      default: return 16000;
    endcase
  endfunction

  function automatic longint sx(input logic [NIN-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sout(input logic [NOUT-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic hist_clear();
    hist.delete();
    for (int i = 0; i < 11; i++) hist.push_back(0);
  endtask

  task automatic hist_push(input logic [NIN-1:0] v);
    hist.push_front(sx(v));
    void'(hist.pop_back());
  endtask

  // y = round(sum h[i]*x[n-i] / 2^SHIFT), then saturate or wrap to NOUT bits
  function automatic longint model();
    longint acc, r;
    logic [NOUT-1:0] w;
    acc = 0;
    for (int i = 0; i < 11; i++) acc += hfull(i) * hist[i];
    r = (acc + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
`ifdef CIC_COMP_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
`else
    w = NOUT'(r);
    return sout(w);
`endif
  endfunction

  // Drive one en pulse and observe the 8 following cycles (no checking here).
  task automatic send_one(input logic [NIN-1:0] v, output int vat, output int vcnt,
                          output int ocnt, output logic [NOUT-1:0] dsamp);
    vat = -1; vcnt = 0; ocnt = 0; dsamp = '0;
    en = 1'b1; din = v;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) en = 1'b0;
      if (valid) begin vcnt++; vat = i; dsamp = dout; end
      if (overrun) ocnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    total++;
    if (valid !== 1'b0 || dout !== '0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b dout=%h overrun=%b, want 0/0/0", valid, dout, overrun);
    end
    rst = 1'b0;
    hist_clear();
    @(negedge clk);
  endtask

  // Run a stream at spacing 8 and compare every output and its timing.
  task automatic run_stream(input string name, input logic [NIN-1:0] v);
    int vat, vcnt, ocnt;
    logic [NOUT-1:0] d;
    longint e;
    hist_push(v);
    e = model();
    last_exp = e;
    send_one(v, vat, vcnt, ocnt, d);
    total++;
    if (vat != 8 || vcnt != 1 || ocnt != 0) begin
      bad++;
      $display("FAIL %s_timing: valid_at=%0d count=%0d overruns=%0d, want 8/1/0", name, vat, vcnt, ocnt);
    end
    total++;
    if (sout(d) !== e) begin
      bad++;
      $display("FAIL %s_dout: got %0d want %0d", name, sout(d), e);
    end
  endtask

  task automatic test_impulse();
    logic [NIN-1:0] v;
    v = {1'b0, {(NIN-1){1'b1}}};
    run_stream("impulse", v);
    for (int i = 0; i < 11; i++) run_stream("impulse", '0);
  endtask

  task automatic test_dc();
    logic [NIN-1:0] v;
    v = NIN'(1 << 19);
    for (int i = 0; i < 13; i++) run_stream("dc_pos", v);
    total++;
    if (sout(dout) !== 64'sd16384) begin
      bad++; $display("FAIL dc_pos_settle: got %0d want 16384", sout(dout));
    end
    v = {1'b1, {(NIN-1){1'b0}}};
    for (int i = 0; i < 13; i++) run_stream("dc_neg", v);
    total++;
    if (sout(dout) !== -64'sd32768) begin
      bad++; $display("FAIL dc_neg_settle: got %0d want -32768", sout(dout));
    end
  endtask

  task automatic test_sat();
    logic [NIN-1:0] v;
    longint want;
    v = {1'b0, {(NIN-1){1'b1}}};
`ifdef CIC_COMP_SAT_EN
    want = 32767;
`else
    want = -32768;
`endif
    for (int i = 0; i < 13; i++) run_stream("sat", v);
    total++;
    if (sout(dout) !== want) begin
      bad++; $display("FAIL sat_settle: got %0d want %0d", sout(dout), want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) run_stream("random", NIN'($urandom));
  endtask

  task automatic test_hold();
    int vc;
    vc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) vc++;
    end
    total++;
    if (vc != 0 || sout(dout) !== last_exp) begin
      bad++; $display("FAIL hold: valids=%0d dout=%0d, want 0 and %0d", vc, sout(dout), last_exp);
    end
  endtask

  // en every 5 cycles: every second request lands in MAC and is dropped.
  task automatic test_overrun();
    logic [NIN-1:0] vals[6];
    longint exp_q[$];
    longint got_q[$];
    int ov;
    ov = 0;
    for (int i = 0; i < 6; i++) vals[i] = NIN'($urandom);
    for (int i = 0; i < 6; i += 2) begin
      hist_push(vals[i]);
      exp_q.push_back(model());
    end
    for (int n = 0; n < 36; n++) begin
      en  = (n % 5 == 0) && (n < 30);
      din = vals[(n / 5) % 6];
      @(negedge clk);
      if (valid) got_q.push_back(sout(dout));
      if (overrun) ov++;
    end
    en = 1'b0;
    total++;
    if (ov != 3 || got_q.size() != 3) begin
      bad++; $display("FAIL overrun_count: overruns=%0d valids=%0d, want 3/3", ov, got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL overrun_dout%0d: got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    last_exp = exp_q[2];
  endtask

  task automatic test_reset_mid();
    int vc;
    logic [NIN-1:0] v;
    en = 1'b1; din = NIN'($urandom) | NIN'(1);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (valid !== 1'b0 || dout !== '0 || overrun !== 1'b0) begin
      bad++; $display("FAIL reset_mid_async: valid=%b dout=%h overrun=%b, want 0/0/0", valid, dout, overrun);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hist_clear();
    vc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) vc++;
    end
    total++;
    if (vc != 0) begin
      bad++; $display("FAIL reset_mid_novalid: valids=%0d want 0", vc);
    end
    v = NIN'($urandom);
    run_stream("post_reset", v);
  endtask

  // Cosine at CIC output scale (12-bit amplitude times R^N = 512 gain).
  task automatic test_chain();
    int c;
    for (int n = 0; n < 32; n++) begin
      c = $rtoi($floor(2047.0 * $cos(2.0 * 3.14159265358979 * n / 16.0) + 0.5));
      run_stream("chain", NIN'(c * 512));
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_sat();
    test_random();
    test_hold();
    test_overrun();
    test_reset_mid();
    test_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
